// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared constants, state encoding and helpers for the UART transmit path.
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Rounded divide, so 50 MHz / 9600 gives 5208.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction
endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Bus-side write port of the UART transmitter: data, strobe and FIFO status.
interface uart_tx_fifo_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic [DATA_BITS-1:0]        din;
   logic                        enable;
   logic                        ready;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] level;

   modport master (output din, output enable, input ready, input overflow, input level);
   modport slave  (input din, input enable, output ready, output overflow, output level);
endinterface

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; the head word is readable
// combinationally and is consumed by pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_ok, pop_ok;

   // A push while full is dropped even if a pop happens in the same cycle.
   always_comb begin
      push_ok  = push && !full_q;
      pop_ok   = pop && !empty_q;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;
   assign count   = count_q;
endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO in front of a frame serialiser with
// configurable data width, parity and stop bits.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | line idle high, waiting for the FIFO to hold a word
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out LSB first
// ST_PARITY | driving the precomputed parity bit
// ST_STOP   | driving STOP_BITS stop bits; may chain straight into START
module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                 clk_in,
   input  logic                 reset,
   uart_tx_fifo_param_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic                 tx
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS) + 1;
   localparam logic [BW-1:0] BAUD_TC   = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic          PAR_INV   = (PARITY == PAR_ODD);
   localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

   uart_state_e            state_q, state_d;
   logic [BW-1:0]          baud_q, baud_d;
   logic [IW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   overflow_q, overflow_d;

   logic                   baud_tc;
   logic                   load;
   logic                   pop;
   logic [DATA_BITS-1:0]   head;
   logic                   fifo_full;
   logic                   fifo_empty;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_in),
      .rst_n   (reset),
      .push    (bus.enable),
      .pop     (pop),
      .wr_data (bus.din),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (bus.level)
   );

   assign baud_tc = (baud_q == BAUD_TC);

   always_comb begin
      state_d    = state_q;
      baud_d     = (state_q == ST_IDLE || baud_tc) ? '0 : baud_q + BW'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      done_d     = 1'b0;
      load       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         ST_IDLE: load = !fifo_empty;
         ST_START: begin
            if (baud_tc) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (baud_tc) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_DATA) begin
                  state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + IW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (baud_tc) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (baud_tc) begin
               bit_d = bit_q + IW'(1);
               if (bit_q == LAST_STOP) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  state_d = ST_IDLE;
                  load    = !fifo_empty;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Parity is fixed at load time so the shifter can discard bits freely.
      if (load) begin
         pop     = 1'b1;
         shift_d = head;
         par_d   = (^head) ^ PAR_INV;
         state_d = ST_START;
         bit_d   = '0;
         baud_d  = '0;
      end

      case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
         ST_PARITY: tx_d = par_q;
         default:   tx_d = 1'b1;
      endcase

      busy_d     = !fifo_empty || (state_q != ST_IDLE);
      overflow_d = bus.enable && fifo_full;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.ready    = !fifo_full;
   assign bus.overflow = overflow_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign tx           = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: four configurations driven from one clock.
module tb_uart_tx_fifo_param;
   import uart_pkg::*;

   localparam int CPB  = 4;
   localparam int HIST = 2048;

   logic clk_in  = 1'b0;
   logic rst_n_a = 1'b0;
   logic rst_n_o = 1'b0;
   int   cyc     = 0;
   int   total   = 0;
   int   bad     = 0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
   uart_tx_fifo_param_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if_b ();
   uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_c ();
   uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_d ();
   logic busy_a, done_a, tx_a, busy_b, done_b, tx_b;
   logic busy_c, done_c, tx_c, busy_d, done_d, tx_d;

   uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(16))
      u_a (.clk_in(clk_in), .reset(rst_n_a), .bus(if_a), .busy(busy_a), .done(done_a), .tx(tx_a));
   uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(16))
      u_b (.clk_in(clk_in), .reset(rst_n_o), .bus(if_b), .busy(busy_b), .done(done_b), .tx(tx_b));
   uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16))
      u_c (.clk_in(clk_in), .reset(rst_n_o), .bus(if_c), .busy(busy_c), .done(done_c), .tx(tx_c));
   uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_d (.clk_in(clk_in), .reset(rst_n_o), .bus(if_d), .busy(busy_d), .done(done_d), .tx(tx_d));

   // Per-cycle history of outputs, indexed by the number of the preceding rising edge.
   logic       tx_h   [4][HIST];
   logic       done_h [4][HIST];
   logic       busy_h [4][HIST];
   logic       rdy_h  [4][HIST];
   logic       ovf_h  [4][HIST];
   logic [4:0] lvl_h  [4][HIST];

   function automatic logic [10:0] ix(input int c);
      return c[10:0];
   endfunction

   always @(negedge clk_in) begin
      if (cyc < HIST) begin
         tx_h[0][ix(cyc)] <= tx_a; done_h[0][ix(cyc)] <= done_a; busy_h[0][ix(cyc)] <= busy_a;
         rdy_h[0][ix(cyc)] <= if_a.ready; ovf_h[0][ix(cyc)] <= if_a.overflow; lvl_h[0][ix(cyc)] <= if_a.level;
         tx_h[1][ix(cyc)] <= tx_b; done_h[1][ix(cyc)] <= done_b; busy_h[1][ix(cyc)] <= busy_b;
         rdy_h[1][ix(cyc)] <= if_b.ready; ovf_h[1][ix(cyc)] <= if_b.overflow; lvl_h[1][ix(cyc)] <= if_b.level;
         tx_h[2][ix(cyc)] <= tx_c; done_h[2][ix(cyc)] <= done_c; busy_h[2][ix(cyc)] <= busy_c;
         rdy_h[2][ix(cyc)] <= if_c.ready; ovf_h[2][ix(cyc)] <= if_c.overflow; lvl_h[2][ix(cyc)] <= if_c.level;
         tx_h[3][ix(cyc)] <= tx_d; done_h[3][ix(cyc)] <= done_d; busy_h[3][ix(cyc)] <= busy_d;
         rdy_h[3][ix(cyc)] <= if_d.ready; ovf_h[3][ix(cyc)] <= if_d.overflow; lvl_h[3][ix(cyc)] <= {2'b00, if_d.level};
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Holds enable for one rising edge; e_n returns the number of that edge.
   task automatic push(input int sel, input logic [7:0] b, output int e_n);
      case (sel)
         0:       begin if_a.din = b;      if_a.enable = 1'b1; end
         1:       begin if_b.din = b[6:0]; if_b.enable = 1'b1; end
         2:       begin if_c.din = b;      if_c.enable = 1'b1; end
         default: begin if_d.din = b;      if_d.enable = 1'b1; end
      endcase
      e_n = cyc + 1;
      @(negedge clk_in);
      if_a.enable = 1'b0; if_b.enable = 1'b0; if_c.enable = 1'b0; if_d.enable = 1'b0;
   endtask

   task automatic test_reset();
      tick(3);
      total++; if (tx_a !== 1'b1)         begin bad++; $display("FAIL rst_tx: got %b want 1", tx_a); end
      total++; if (if_a.ready !== 1'b1)   begin bad++; $display("FAIL rst_ready: got %b want 1", if_a.ready); end
      total++; if (busy_a !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      total++; if (done_a !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b want 0", done_a); end
      total++; if (if_a.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", if_a.overflow); end
      total++; if (if_a.level !== 5'd0)   begin bad++; $display("FAIL rst_level: got %0d want 0", if_a.level); end
      rst_n_a = 1'b1;
      rst_n_o = 1'b1;
      tick(3);
      total++; if (tx_a !== 1'b1 || tx_d !== 1'b1) begin bad++; $display("FAIL post_rst_tx: got %b%b want 11", tx_a, tx_d); end
      total++; if (if_d.ready !== 1'b1 || busy_d !== 1'b0) begin bad++; $display("FAIL post_rst_d: ready=%b busy=%b want 1 0", if_d.ready, busy_d); end
   endtask

   task automatic test_8n1();
      int e, nd, dpos;
      logic ok;
      logic [9:0] fr;
      fr = {1'b1, 8'h55, 1'b0};
      push(0, 8'h55, e);
      tick(46);
      total++; if (tx_h[0][ix(e+1)] !== 1'b1) begin bad++; $display("FAIL 8n1_latency: tx at e+1 got %b want 1", tx_h[0][ix(e+1)]); end
      for (int k = 0; k < 10; k++) begin
         ok = 1'b1;
         for (int c = 0; c < CPB; c++) if (tx_h[0][ix(e+2+CPB*k+c)] !== fr[k]) ok = 1'b0;
         total++; if (!ok) begin bad++; $display("FAIL 8n1_bit%0d: got %b want %b", k, tx_h[0][ix(e+3+CPB*k)], fr[k]); end
      end
      nd = 0; dpos = -1;
      for (int c = e; c < e + 46; c++) if (done_h[0][ix(c)] === 1'b1) begin nd++; dpos = c; end
      total++; if (nd != 1 || dpos != e + 41) begin bad++; $display("FAIL 8n1_done: got %0d pulses at +%0d want 1 at +41", nd, dpos - e); end
      ok = 1'b1;
      for (int c = e + 1; c <= e + 41; c++) if (busy_h[0][ix(c)] !== 1'b1) ok = 1'b0;
      total++; if (!ok || busy_h[0][ix(e)] !== 1'b0 || busy_h[0][ix(e+42)] !== 1'b0)
         begin bad++; $display("FAIL 8n1_busy: window_ok=%b before=%b after=%b want 1 0 0", ok, busy_h[0][ix(e)], busy_h[0][ix(e+42)]); end
   endtask

   task automatic test_7o2();
      int e, nd, dpos;
      logic ok;
      logic [10:0] fr;
      fr = {2'b11, 1'b1, 7'h03, 1'b0};
      push(1, 8'h03, e);
      tick(50);
      for (int k = 0; k < 11; k++) begin
         ok = 1'b1;
         for (int c = 0; c < CPB; c++) if (tx_h[1][ix(e+2+CPB*k+c)] !== fr[k]) ok = 1'b0;
         total++; if (!ok) begin bad++; $display("FAIL 7o2_bit%0d: got %b want %b", k, tx_h[1][ix(e+3+CPB*k)], fr[k]); end
      end
      nd = 0; dpos = -1;
      for (int c = e; c < e + 50; c++) if (done_h[1][ix(c)] === 1'b1) begin nd++; dpos = c; end
      total++; if (nd != 1 || dpos != e + 45) begin bad++; $display("FAIL 7o2_done: got %0d pulses at +%0d want 1 at +45", nd, dpos - e); end
      total++; if (tx_h[1][ix(e+46)] !== 1'b1 || busy_h[1][ix(e+46)] !== 1'b0)
         begin bad++; $display("FAIL 7o2_idle: tx=%b busy=%b want 1 0", tx_h[1][ix(e+46)], busy_h[1][ix(e+46)]); end
   endtask

   task automatic test_parity_even();
      int e, nd, dpos;
      logic ok;
      logic [10:0] fr;
      logic [7:0] dat [2];
      logic       par [2];
      dat = '{8'h07, 8'h0F};
      par = '{1'b1, 1'b0};
      for (int t = 0; t < 2; t++) begin
         fr = {1'b1, par[t], dat[t], 1'b0};
         push(2, dat[t], e);
         tick(50);
         for (int k = 0; k < 11; k++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) if (tx_h[2][ix(e+2+CPB*k+c)] !== fr[k]) ok = 1'b0;
            total++; if (!ok) begin bad++; $display("FAIL even_%h_bit%0d: got %b want %b", dat[t], k, tx_h[2][ix(e+3+CPB*k)], fr[k]); end
         end
         nd = 0; dpos = -1;
         for (int c = e; c < e + 50; c++) if (done_h[2][ix(c)] === 1'b1) begin nd++; dpos = c; end
         total++; if (nd != 1 || dpos != e + 45) begin bad++; $display("FAIL even_%h_done: got %0d pulses at +%0d want 1 at +45", dat[t], nd, dpos - e); end
      end
   endtask

   task automatic test_overflow();
      int e0, e, nd, offp;
      logic ok;
      logic [9:0] fr;
      logic [7:0] dat [6];
      dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      push(3, dat[0], e0);
      for (int i = 1; i < 6; i++) push(3, dat[i], e);
      tick(210);
      ok = 1'b1;
      for (int c = e0; c <= e0 + 4; c++) if (ovf_h[3][ix(c)] !== 1'b0) ok = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL ovf_early: got spurious overflow want none"); end
      total++; if (ovf_h[3][ix(e0+5)] !== 1'b1 || ovf_h[3][ix(e0+6)] !== 1'b0)
         begin bad++; $display("FAIL ovf_pulse: got %b%b want 10", ovf_h[3][ix(e0+5)], ovf_h[3][ix(e0+6)]); end
      total++; if (rdy_h[3][ix(e0+3)] !== 1'b1 || rdy_h[3][ix(e0+4)] !== 1'b0 || rdy_h[3][ix(e0+5)] !== 1'b0)
         begin bad++; $display("FAIL ovf_ready: got %b%b%b want 100", rdy_h[3][ix(e0+3)], rdy_h[3][ix(e0+4)], rdy_h[3][ix(e0+5)]); end
      total++; if (lvl_h[3][ix(e0+5)] !== 5'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", lvl_h[3][ix(e0+5)]); end
      for (int i = 0; i < 5; i++) begin
         fr = {1'b1, dat[i], 1'b0};
         ok = 1'b1;
         for (int c = 0; c < 10 * CPB; c++) if (tx_h[3][ix(e0+2+40*i+c)] !== fr[c/CPB]) ok = 1'b0;
         total++; if (!ok) begin bad++; $display("FAIL ovf_frame%0d: serial data differs from %h", i, dat[i]); end
      end
      nd = 0; ok = 1'b1;
      for (int c = e0; c < e0 + 214; c++) begin
         if (done_h[3][ix(c)] === 1'b1) begin
            nd++;
            offp = c - e0 - 41;
            if (offp < 0 || offp % 40 != 0) ok = 1'b0;
         end
      end
      total++; if (nd != 5 || !ok) begin bad++; $display("FAIL ovf_done: got %0d pulses aligned=%b want 5 aligned", nd, ok); end
      total++; if (tx_h[3][ix(e0+202)] !== 1'b1 || busy_h[3][ix(e0+202)] !== 1'b0)
         begin bad++; $display("FAIL ovf_end: tx=%b busy=%b want 1 0", tx_h[3][ix(e0+202)], busy_h[3][ix(e0+202)]); end
   endtask

   task automatic test_reset_mid();
      int e, e2, rs, nd, dpos;
      logic ok;
      logic [9:0] fr;
      push(0, 8'h00, e);
      push(0, 8'h3C, e2);
      while (cyc < e + 19) @(negedge clk_in);
      total++; if (tx_a !== 1'b0 || if_a.level !== 5'd1)
         begin bad++; $display("FAIL rmid_pre: tx=%b level=%0d want 0 1", tx_a, if_a.level); end
      rst_n_a = 1'b0;
      rs = cyc;
      #1;
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rmid_tx: got %b want 1", tx_a); end
      total++; if (if_a.level !== 5'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", if_a.level); end
      tick(3);
      rst_n_a = 1'b1;
      tick(60);
      nd = 0; ok = 1'b1;
      for (int c = rs + 1; c < rs + 63; c++) begin
         if (done_h[0][ix(c)] === 1'b1) nd++;
         if (tx_h[0][ix(c)] !== 1'b1) ok = 1'b0;
      end
      total++; if (nd != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", nd); end
      total++; if (!ok) begin bad++; $display("FAIL rmid_line_idle: got activity want idle high"); end
      fr = {1'b1, 8'hA5, 1'b0};
      push(0, 8'hA5, e);
      tick(46);
      for (int k = 0; k < 10; k++) begin
         ok = 1'b1;
         for (int c = 0; c < CPB; c++) if (tx_h[0][ix(e+2+CPB*k+c)] !== fr[k]) ok = 1'b0;
         total++; if (!ok) begin bad++; $display("FAIL rmid_a5_bit%0d: got %b want %b", k, tx_h[0][ix(e+3+CPB*k)], fr[k]); end
      end
      nd = 0; dpos = -1;
      for (int c = e; c < e + 46; c++) if (done_h[0][ix(c)] === 1'b1) begin nd++; dpos = c; end
      total++; if (nd != 1 || dpos != e + 41) begin bad++; $display("FAIL rmid_a5_done: got %0d pulses at +%0d want 1 at +41", nd, dpos - e); end
   endtask

   task automatic test_push_pop();
      int e0, e;
      logic ok;
      logic [9:0] fr;
      logic [7:0] dat [4];
      dat = '{8'h12, 8'h34, 8'h56, 8'h78};
      push(0, dat[0], e0);
      push(0, dat[1], e);
      push(0, dat[2], e);
      while (cyc < e0 + 40) @(negedge clk_in);
      total++; if (if_a.level !== 5'd2) begin bad++; $display("FAIL pp_level_before: got %0d want 2", if_a.level); end
      push(0, dat[3], e);
      total++; if (if_a.level !== 5'd2) begin bad++; $display("FAIL pp_level_same: got %0d want 2", if_a.level); end
      tick(1);
      total++; if (if_a.level !== 5'd2) begin bad++; $display("FAIL pp_level_after: got %0d want 2", if_a.level); end
      while (cyc < e0 + 165) @(negedge clk_in);
      for (int i = 0; i < 4; i++) begin
         fr = {1'b1, dat[i], 1'b0};
         ok = 1'b1;
         for (int c = 0; c < 10 * CPB; c++) if (tx_h[0][ix(e0+2+40*i+c)] !== fr[c/CPB]) ok = 1'b0;
         total++; if (!ok) begin bad++; $display("FAIL pp_frame%0d: serial data differs from %h", i, dat[i]); end
      end
      total++; if (busy_h[0][ix(e0+161)] !== 1'b1 || busy_h[0][ix(e0+162)] !== 1'b0)
         begin bad++; $display("FAIL pp_busy_end: got %b%b want 10", busy_h[0][ix(e0+161)], busy_h[0][ix(e0+162)]); end
   endtask

   initial begin
      if_a.din = '0; if_a.enable = 1'b0;
      if_b.din = '0; if_b.enable = 1'b0;
      if_c.din = '0; if_c.enable = 1'b0;
      if_d.din = '0; if_d.enable = 1'b0;
      test_reset();
      test_8n1();
      test_7o2();
      test_parity_even();
      test_overflow();
      test_reset_mid();
      test_push_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
